// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and limits for the bit-serial adder
package serial_adder_pkg;
  localparam int STATE_W = 2;
  localparam int MAX_WIDTH = 32;
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/fa_bit.sv
// fa_bit: 1-bit full adder built from two half-adder cells and an OR
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic x1, y1, y2;
  assign x1 = a ^ b;
  assign y1 = a & b;
  assign s  = x1 ^ ci;
  assign y2 = x1 & ci;
  assign co = y1 | y2;
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: LSB-first bit-serial adder, one bit per clock; SERIAL_ADDER_SUB_EN adds a subtract mode
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_nx, b_in;
  logic [CNT_W-1:0] cnt;
  logic carry, c_in, s, c, last, take;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif
  fa_bit u_fa (.a(a_sr[0]), .b(b_sr[0]), .ci(carry), .s(s), .co(c));
  assign last   = cnt == CNT_W'(WIDTH - 1);
  assign take   = start && state != SHIFT;
  // shift-in written as an OR so WIDTH=1 needs no empty slice
  assign sum_nx = (sum_sr >> 1) | (WIDTH'(s) << (WIDTH - 1));
  assign busy   = state == SHIFT;
  assign done   = state == DONE;
  always_comb begin
    state_nx = state == SHIFT ? (last ? DONE : SHIFT) : (start ? SHIFT : IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (take) begin
      a_sr   <= a;
      b_sr   <= b_in;
      sum_sr <= '0;
      carry  <= c_in;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= sum_nx;
      carry  <= c;
      cnt    <= cnt + CNT_W'(1);
      if (last) begin
        sum  <= sum_nx;
        cout <= c;
      end
    end
  end
endmodule
